qpsk_prbs_ctrl: RTL and testbench

Sequencer for the QPSK test-pattern source. It owns two PRBS9 generators, one for the I rail and one for the Q rail. It loads their seeds, advances them once per symbol at the oversampled rate, and runs bursts of a programmed symbol count. It sits between the control registers (start/stop/length) and the QPSK mapper and upsampling filter, which consume `o_bit_i`, `o_bit_q` and `o_valid`.

---
 rtl/qpsk_pkg.sv | 20 ++
 rtl/qpsk_prbs_ctrl_if.sv | 26 ++
 rtl/qpsk_prbs_ctrl_prbs9_ce.sv | 29 ++
 rtl/qpsk_prbs_ctrl.sv | 118 +++++++++++
 tb/tb_qpsk_prbs_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared types, PRBS9 taps and default seeds for the QPSK pattern source
package qpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Feedback taps of x^9 + x^5 + 1 in a left-shifting register: bits 8 and 4
  localparam logic [8:0] PRBS9_TAPS     = 9'h110;
  localparam logic [8:0] DEFAULT_SEED_I = 9'h0AB;
  localparam logic [8:0] DEFAULT_SEED_Q = 9'h1FE;

  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], ^(s & PRBS9_TAPS)};
  endfunction

endpackage

// File: rtl/qpsk_prbs_ctrl_if.sv
// rtl/qpsk_prbs_ctrl_if.sv - control and symbol-stream bundle between register block, sequencer and mapper
interface qpsk_prbs_ctrl_if #(
  parameter int LEN_W = 16
);

  logic             i_start;
  logic             i_stop;
  logic [LEN_W-1:0] i_len;
  logic             o_bit_i;
  logic             o_bit_q;
  logic             o_valid;
  logic             o_busy;
  logic             o_done;
  logic [LEN_W-1:0] o_count;

  modport master (
    output i_start, i_stop, i_len,
    input  o_bit_i, o_bit_q, o_valid, o_busy, o_done, o_count
  );

  modport slave (
    input  i_start, i_stop, i_len,
    output o_bit_i, o_bit_q, o_valid, o_busy, o_done, o_count
  );

endinterface

// File: rtl/qpsk_prbs_ctrl_prbs9_ce.sv
// rtl/qpsk_prbs_ctrl_prbs9_ce.sv - PRBS9 generator with clock enable and synchronous seed load
module prbs9_ce
  import qpsk_pkg::*;
#(
  parameter logic [8:0] SEED = DEFAULT_SEED_I
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic ce,
  output logic bit_out
);

  logic [8:0] s_q;

  // Load wins over advance so a reload never picks up a stale step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= SEED;
    end else if (load) begin
      s_q <= SEED;
    end else if (ce) begin
      s_q <= prbs9_next(s_q);
    end
  end

  assign bit_out = s_q[8];

endmodule

// File: rtl/qpsk_prbs_ctrl.sv
// rtl/qpsk_prbs_ctrl.sv - burst sequencer driving the I/Q PRBS9 rails at one symbol per OS clocks
module qpsk_prbs_ctrl
  import qpsk_pkg::*;
#(
  parameter int         OS     = 4,
  parameter logic [8:0] SEED_I = DEFAULT_SEED_I,
  parameter logic [8:0] SEED_Q = DEFAULT_SEED_Q,
  parameter int         LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  qpsk_prbs_ctrl_if.slave  bus
);

  localparam int             PH_W    = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [PH_W-1:0]  phase_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_inc;
  logic             start_ok;
  logic             valid;
  logic             busy;
  logic             done;
  logic             lfsr_load;

  assign start_ok  = bus.i_start && (bus.i_len != '0);
  assign count_inc = count_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_LOAD;
      ST_LOAD: state_d = bus.i_stop ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (bus.i_stop || (valid && (count_inc == len_q))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    lfsr_load = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        busy      = 1'b1;
        lfsr_load = 1'b1;
      end
      ST_RUN: begin
        busy  = 1'b1;
        valid = (phase_q == PH_LAST);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // The length is captured only on an accepted start, so mid-burst starts cannot disturb it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start_ok) begin
        len_q <= bus.i_len;
      end
      if (lfsr_load) begin
        phase_q <= '0;
        count_q <= '0;
      end else if (state_q == ST_RUN) begin
        phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        if (valid) begin
          count_q <= count_inc;
        end
      end
    end
  end

  prbs9_ce #(.SEED(SEED_I)) u_prbs_i (
    .clk     (clk),
    .rst_n   (rst),
    .load    (lfsr_load),
    .ce      (valid),
    .bit_out (bus.o_bit_i)
  );

  prbs9_ce #(.SEED(SEED_Q)) u_prbs_q (
    .clk     (clk),
    .rst_n   (rst),
    .load    (lfsr_load),
    .ce      (valid),
    .bit_out (bus.o_bit_q)
  );

  assign bus.o_valid = valid;
  assign bus.o_busy  = busy;
  assign bus.o_done  = done;
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_qpsk_prbs_ctrl.sv
// tb/tb_qpsk_prbs_ctrl.sv - self-checking bench for the QPSK PRBS burst sequencer
module tb_qpsk_prbs_ctrl;

  localparam int         OS = 4;
  localparam logic [8:0] SI = 9'h0AB;
  localparam logic [8:0] SQ = 9'h1FE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  qpsk_prbs_ctrl_if #(.LEN_W(16)) bus();

  qpsk_prbs_ctrl #(.OS(OS), .SEED_I(SI), .SEED_Q(SQ), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Symbol scoreboard: output bit sequence obeys y[k] = y[k-9] ^ y[k-5]
  always @(negedge clk) begin
    if (rst && bus.o_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got i=%0b q=%0b expected no strobe at %0t", bus.o_bit_i, bus.o_bit_q, $time);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({bus.o_bit_i, bus.o_bit_q} !== e) begin
          errors++;
          $display("FAIL symbol got iq=%b expected iq=%b at %0t", {bus.o_bit_i, bus.o_bit_q}, e, $time);
        end
      end
    end
  end

  task automatic push_expected(input int n);
    logic yi[0:600];
    logic yq[0:600];
    logic [8:0] si;
    logic [8:0] sq;
    si = SI;
    sq = SQ;
    for (int k = 0; k < 9; k++) begin
      yi[k] = si[8-k];
      yq[k] = sq[8-k];
    end
    for (int k = 9; k < 601; k++) begin
      yi[k] = yi[k-9] ^ yi[k-5];
      yq[k] = yq[k-9] ^ yq[k-5];
    end
    for (int k = 0; k < n; k++) exp_q.push_back({yi[k], yq[k]});
  endtask

  // Returns at the negedge inside cycle 1 (LOAD) of the new burst
  task automatic start_burst(input int len);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = 16'(len);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int start_cyc, input int limit, output int cyc);
    cyc = start_cyc;
    while (bus.o_done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got %0d pending symbols expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    bus.i_len   = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.o_valid); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.o_busy); end
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.o_done); end
    if (bus.o_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus.o_count); end
    if (bus.o_bit_i !== 1'b0) begin errors++; $display("FAIL reset_bit_i got %b expected 0", bus.o_bit_i); end
    if (bus.o_bit_q !== 1'b1) begin errors++; $display("FAIL reset_bit_q got %b expected 1", bus.o_bit_q); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2:0] ibits;
    int         vi;
    ibits = 3'b010;
    vi = 0;
    push_expected(3);
    start_burst(3);
    for (int c = 1; c <= 15; c++) begin
      logic ev;
      logic ed;
      logic eb;
      if (c > 1) @(negedge clk);
      ev = (c == 5 || c == 9 || c == 13);
      ed = (c == 14);
      eb = (c >= 1 && c <= 13);
      checks += 3;
      if (bus.o_valid !== ev) begin errors++; $display("FAIL basic_valid c%0d got %b expected %b", c, bus.o_valid, ev); end
      if (bus.o_done !== ed) begin errors++; $display("FAIL basic_done c%0d got %b expected %b", c, bus.o_done, ed); end
      if (bus.o_busy !== eb) begin errors++; $display("FAIL basic_busy c%0d got %b expected %b", c, bus.o_busy, eb); end
      if (ev) begin
        checks++;
        if (bus.o_bit_i !== ibits[2-vi]) begin
          errors++;
          $display("FAIL basic_bit_i sym%0d got %b expected %b", vi + 1, bus.o_bit_i, ibits[2-vi]);
        end
        vi++;
      end
      if (ed) begin
        checks++;
        if (bus.o_count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d expected 3", bus.o_count); end
      end
    end
    check_drained("basic");
  endtask

  task automatic test_long();
    int cyc;
    push_expected(511);
    start_burst(511);
    wait_done(1, 2100, cyc);
    checks += 2;
    if (cyc != 2 + 511 * OS) begin errors++; $display("FAIL long_done_cycle got %0d expected %0d", cyc, 2 + 511 * OS); end
    if (bus.o_count !== 16'd511) begin errors++; $display("FAIL long_count got %0d expected 511", bus.o_count); end
    check_drained("long");
    // Earliest restart: start sampled at the end of the first IDLE cycle
    push_expected(5);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = 16'd5;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL long_restart_busy got %b expected 1", bus.o_busy); end
    wait_done(1, 40, cyc);
    checks++;
    if (cyc != 2 + 5 * OS) begin errors++; $display("FAIL long_restart_done got %0d expected %0d", cyc, 2 + 5 * OS); end
    check_drained("long_restart");
  endtask

  task automatic test_back_to_back();
    int cyc;
    push_expected(3);
    start_burst(3);
    wait_done(1, 40, cyc);
    push_expected(4);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = 16'd4;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(1, 40, cyc);
    checks += 2;
    if (cyc != 2 + 4 * OS) begin errors++; $display("FAIL b2b_done_cycle got %0d expected %0d", cyc, 2 + 4 * OS); end
    if (bus.o_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d expected 4", bus.o_count); end
    check_drained("b2b");
  endtask

  task automatic test_stop(input int stop_cyc, input int exp_cnt, input string name);
    push_expected(exp_cnt);
    start_burst(10);
    for (int c = 2; c <= stop_cyc; c++) @(negedge clk);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    checks += 3;
    if (bus.o_done !== 1'b1) begin errors++; $display("FAIL %s_done got %b expected 1", name, bus.o_done); end
    if (bus.o_count !== 16'(exp_cnt)) begin errors++; $display("FAIL %s_count got %0d expected %0d", name, bus.o_count, exp_cnt); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b expected 0", name, bus.o_busy); end
    repeat (20) @(negedge clk);
    check_drained(name);
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_len   = 16'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks += 2;
      if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL len0_busy c%0d got %b expected 0", c, bus.o_busy); end
      if (bus.o_done !== 1'b0) begin errors++; $display("FAIL len0_done c%0d got %b expected 0", c, bus.o_done); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_in_run();
    int cyc;
    push_expected(3);
    start_burst(3);
    for (int c = 2; c <= 13; c++) begin
      @(negedge clk);
      bus.i_start = (c % 3 == 0);
      bus.i_len   = 16'd7;
    end
    bus.i_start = 1'b0;
    wait_done(13, 40, cyc);
    checks += 2;
    if (cyc != 14) begin errors++; $display("FAIL run_start_done got %0d expected 14", cyc); end
    if (bus.o_count !== 16'd3) begin errors++; $display("FAIL run_start_count got %0d expected 3", bus.o_count); end
    repeat (10) @(negedge clk);
    check_drained("run_start");
  endtask

  task automatic test_async_reset();
    int cyc;
    push_expected(1);
    start_burst(10);
    for (int c = 2; c <= 8; c++) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks += 6;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b expected 0", bus.o_busy); end
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b expected 0", bus.o_valid); end
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL areset_done got %b expected 0", bus.o_done); end
    if (bus.o_count !== 16'd0) begin errors++; $display("FAIL areset_count got %0d expected 0", bus.o_count); end
    if (bus.o_bit_i !== SI[8]) begin errors++; $display("FAIL areset_bit_i got %b expected %b", bus.o_bit_i, SI[8]); end
    if (bus.o_bit_q !== SQ[8]) begin errors++; $display("FAIL areset_bit_q got %b expected %b", bus.o_bit_q, SQ[8]); end
    check_drained("areset_pre");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0) begin errors++; $display("FAIL areset_no_done got %b expected 0", bus.o_done); end
    end
    push_expected(3);
    start_burst(3);
    wait_done(1, 40, cyc);
    checks += 2;
    if (cyc != 14) begin errors++; $display("FAIL areset_fresh_done got %0d expected 14", cyc); end
    if (bus.o_count !== 16'd3) begin errors++; $display("FAIL areset_fresh_count got %0d expected 3", bus.o_count); end
    check_drained("areset_fresh");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long();
    test_back_to_back();
    test_stop(10, 2, "stop_run");
    test_stop(17, 4, "stop_strobe");
    test_len_zero();
    test_start_in_run();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
